// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice.
//   fetch_state_e : controller state encoding
//   fetch_entry_t : one prefetch-buffer entry {pc, inst}
//   INST_BYTES    : bytes per instruction word
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned PC_W       = 64;
    localparam int unsigned INST_W     = 32;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset (clears pointers, count and storage)
//   flush      : drop all entries (takes priority over push/pop)
//   push, pop  : write push_data / remove head; both together allowed even when full
//   push_data  : entry to write
//   head       : oldest entry (don't-care when empty)
//   full/empty : occupancy flags decoded from the count register
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational
// instruction memory and buffers fetched words for the decode stage.
//   clk, rst_n        : clock, async active-low reset
//   start             : leave IDLE and begin fetching at the current PC
//   redirect_valid/pc : taken branch/jump; flushes the buffer and reloads the PC
//   imem_addr         : memory address (the PC register)
//   imem_rdata        : instruction word returned by memory this cycle
//   out_valid/ready   : decode handshake; out_inst/out_pc carry the head entry
//   fault             : controller is in FAULT
//   busy              : controller is in RUN
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned MEM_BYTES  = 88,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic        busy
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         busy_q, fault_q;

    logic         fifo_full, fifo_empty;
    logic         pc_legal, pop, push;
    logic [64:0]  pc_end;
    fetch_entry_t push_entry, head_entry;

    // 65-bit end address so a PC near 2^64 cannot wrap into the legal range
    assign pc_end   = {1'b0, pc_q} + 65'(INST_BYTES);
    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_end <= 65'(MEM_BYTES));

    // A pop coinciding with a redirect is discarded along with the flushed entries
    assign pop  = !fifo_empty && out_ready && !redirect_valid;
    assign push = (state_q == FS_RUN) && pc_legal && !redirect_valid && (!fifo_full || pop);

    assign push_entry.pc   = pc_q;
    assign push_entry.inst = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next state and next PC; a redirect overrides everything else
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            FS_IDLE: begin
                if (start) begin
                    state_d = FS_RUN;
                end
            end
            FS_RUN: begin
                if (!pc_legal) begin
                    state_d = FS_FAULT;
                end else if (push) begin
                    pc_d = pc_q + 64'(INST_BYTES);
                end
            end
            FS_FAULT: begin
                state_d = FS_FAULT;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (state_q != FS_IDLE) begin
                state_d = FS_RUN;
            end
        end
    end

    // State, PC and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= (state_d == FS_RUN);
            fault_q <= (state_d == FS_FAULT);
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = !fifo_empty;
    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;
    assign fault     = fault_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational 88-byte
// instruction memory holding a bubble-sort image.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        fault;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [22];

    fetch_sequencer #(
        .RESET_PC   (64'h0),
        .MEM_BYTES  (88),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault),
        .busy           (busy)
    );

    // Combinational instruction memory
    always_comb begin
        imem_rdata = 32'h0;
        if (imem_addr < 64'd88) begin
            imem_rdata = rom[imem_addr[6:2]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom = '{32'h00000913, 32'h00000433, 32'h04b40863, 32'h00000493,
                32'h40b00333, 32'hfff30313, 32'h0264d463, 32'h00249393,
                32'h007503b3, 32'h0003a283, 32'h0043ae03, 32'h005e5663,
                32'h01c3a023, 32'h0053a223, 32'hfe0004e3, 32'h00148493,
                32'hfc5ff06f, 32'h00140413, 32'h00100913, 32'hfa091ae3,
                32'h00008067, 32'hfa000ae3};

        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;

        // Reset values
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fault",     64'(fault),     64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_inst",  64'(out_inst),  64'd0);
        chk("rst_out_pc",    out_pc,         64'd0);
        chk("rst_imem_addr", imem_addr,      64'd0);
        rst_n = 1'b1;

        // 1: start with decode always ready
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_c1",      64'(busy),      64'd1);
        chk("t1_valid_c1",     64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_c2",     64'(out_valid), 64'd1);
        chk("t1_pc_c2",        out_pc,         64'h0);
        chk("t1_inst_c2",      64'(out_inst),  64'h00000913);
        tick();
        chk("t1_pc_c3",        out_pc,         64'h4);
        chk("t1_inst_c3",      64'(out_inst),  64'h00000433);
        tick();
        chk("t1_pc_c4",        out_pc,         64'h8);
        chk("t1_inst_c4",      64'(out_inst),  64'h04b40863);

        // 2: backpressure after a fresh start
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t2_valid_held",  64'(out_valid), 64'd1);
        chk("t2_head_held",   out_pc,         64'h0);
        chk("t2_addr_held",   imem_addr,      64'h8);
        out_ready = 1'b1;
        chk("t2_rel_pc0",     out_pc,         64'h0);
        tick();
        chk("t2_rel_pc4",     out_pc,         64'h4);
        tick();
        chk("t2_rel_pc8",     out_pc,         64'h8);
        chk("t2_rel_inst8",   64'(out_inst),  64'h04b40863);

        // 3: redirect while full and popping
        redirect_valid = 1'b1;
        redirect_pc    = 64'h38;
        tick();
        redirect_valid = 1'b0;
        chk("t3_valid_flush", 64'(out_valid), 64'd0);
        chk("t3_addr",        imem_addr,      64'h38);
        tick();
        chk("t3_valid",       64'(out_valid), 64'd1);
        chk("t3_pc",          out_pc,         64'h38);
        chk("t3_inst",        64'(out_inst),  64'hfe0004e3);

        // 4: run off the end of memory
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t4_stream_pc", out_pc, 64'h38 + 64'(4 * k));
        end
        chk("t4_last_inst",   64'(out_inst),  64'hfa000ae3);
        chk("t4_no_fault_yet",64'(fault),     64'd0);
        tick();
        chk("t4_fault",       64'(fault),     64'd1);
        chk("t4_busy",        64'(busy),      64'd0);
        chk("t4_empty",       64'(out_valid), 64'd0);
        chk("t4_addr",        imem_addr,      64'h58);
        tick();
        tick();
        chk("t4_no_58_entry", 64'(out_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        chk("t4_recover_fault", 64'(fault),   64'd0);
        chk("t4_recover_busy",  64'(busy),    64'd1);
        tick();
        chk("t4_recover_valid", 64'(out_valid), 64'd1);
        chk("t4_recover_pc",    out_pc,         64'h0);
        chk("t4_recover_inst",  64'(out_inst),  64'h00000913);

        // 5: misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 64'h6;
        tick();
        redirect_valid = 1'b0;
        chk("t5_valid_c1",    64'(out_valid), 64'd0);
        tick();
        chk("t5_fault",       64'(fault),     64'd1);
        chk("t5_valid_c2",    64'(out_valid), 64'd0);
        chk("t5_addr",        imem_addr,      64'h6);
        tick();
        chk("t5_valid_c3",    64'(out_valid), 64'd0);

        // 6: async reset between edges while running
        redirect_valid = 1'b1;
        redirect_pc    = 64'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("t6_running",     64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",   64'(out_valid), 64'd0);
        chk("t6_rst_addr",    imem_addr,      64'h0);
        chk("t6_rst_busy",    64'(busy),      64'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle_addr",   imem_addr,      64'h0);
        chk("t6_idle_valid",  64'(out_valid), 64'd0);
        chk("t6_idle_busy",   64'(busy),      64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_restart_pc",  out_pc,         64'h0);
        chk("t6_restart_val", 64'(out_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
